syn_lb_fabric: RTL



---
 rtl/syn_lb_fabric.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/syn_lb_fabric.sv
// Local-bus fabric: registers one master request, routes it to the slave picked by the upper
// address bits, and returns its completion, a decode-miss error or a timeout error.
module syn_lb_fabric #(
    parameter int                  P_NUM_SLAVES = 4,
    parameter int                  P_DATA_W     = 32,
    parameter int                  P_ADDR_W     = 16,
    parameter int                  P_SLV_ADDR_W = 12,
    parameter int                  P_TIMEOUT    = 255,
    parameter logic [P_DATA_W-1:0] P_ERR_DATA   = 'hDEADBABE
) (
    input  logic                             clk_ir,
    input  logic                             rst_il,
    input  logic                             mst_rd_en,
    input  logic                             mst_wr_en,
    input  logic [P_ADDR_W-1:0]              mst_addr,
    input  logic [P_DATA_W-1:0]              mst_wr_data,
    output logic                             mst_rd_valid,
    output logic                             mst_wr_valid,
    output logic [P_DATA_W-1:0]              mst_rd_data,
    output logic                             mst_err,
    output logic                             mst_busy,
    output logic [7:0]                       err_cnt,
    output logic [P_NUM_SLAVES-1:0]          slv_rd_en,
    output logic [P_NUM_SLAVES-1:0]          slv_wr_en,
    output logic [P_SLV_ADDR_W-1:0]          slv_addr,
    output logic [P_DATA_W-1:0]              slv_wr_data,
    input  logic [P_NUM_SLAVES-1:0]          slv_rd_valid,
    input  logic [P_NUM_SLAVES-1:0]          slv_wr_valid,
    input  logic [P_NUM_SLAVES*P_DATA_W-1:0] slv_rd_data
);

    localparam int SEL_W = P_ADDR_W - P_SLV_ADDR_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                  state;
    logic [SEL_W-1:0]        sel_p0;
    logic [P_SLV_ADDR_W-1:0] addr_p0;
    logic [P_DATA_W-1:0]     wdata_p0;
    logic                    dir_wr_p0;
    logic [15:0]             tmo_cnt;

    logic [SEL_W-1:0]        req_sel;
    logic                    req_any;
    logic                    req_mapped;
    logic [P_NUM_SLAVES-1:0] req_onehot;
    logic [P_NUM_SLAVES-1:0] sel_onehot;
    logic [P_NUM_SLAVES-1:0] allow_rd;
    logic [P_NUM_SLAVES-1:0] allow_wr;
    logic                    hit;
    logic                    stray;
    logic                    timeout;
    logic                    violation;
    logic [P_DATA_W-1:0]     rd_mux;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign req_sel    = mst_addr[P_ADDR_W-1:P_SLV_ADDR_W];
    assign req_any    = mst_rd_en | mst_wr_en;
    assign req_mapped = 32'(req_sel) < P_NUM_SLAVES;
    assign req_onehot = P_NUM_SLAVES'(1) << req_sel;
    assign sel_onehot = P_NUM_SLAVES'(1) << sel_p0;

    // Only the captured slave, in the captured direction, may answer while a transaction is live.
    assign allow_rd   = (state != IDLE && !dir_wr_p0) ? sel_onehot : '0;
    assign allow_wr   = (state != IDLE &&  dir_wr_p0) ? sel_onehot : '0;
    assign hit        = |(slv_rd_valid & allow_rd) | |(slv_wr_valid & allow_wr);
    assign stray      = |(slv_rd_valid & ~allow_rd) | |(slv_wr_valid & ~allow_wr);
    assign timeout    = (state == WAIT) && !hit && (tmo_cnt == 16'(P_TIMEOUT - 1));
    assign violation  = stray | timeout |
                        ((state == IDLE) ? (mst_rd_en & mst_wr_en) : req_any);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < P_NUM_SLAVES; i++) begin
            if (sel_p0 == SEL_W'(i)) rd_mux = slv_rd_data[i*P_DATA_W +: P_DATA_W];
        end
    end

    assign mst_busy    = (state != IDLE);
    assign slv_addr    = addr_p0;
    assign slv_wr_data = wdata_p0;

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state        <= IDLE;
            sel_p0       <= '0;
            addr_p0      <= '0;
            wdata_p0     <= '0;
            dir_wr_p0    <= 1'b0;
            tmo_cnt      <= '0;
            err_cnt      <= '0;
            mst_rd_valid <= 1'b0;
            mst_wr_valid <= 1'b0;
            mst_rd_data  <= '0;
            mst_err      <= 1'b0;
            slv_rd_en    <= '0;
            slv_wr_en    <= '0;
        end else begin
            mst_rd_valid <= 1'b0;
            mst_wr_valid <= 1'b0;
            mst_rd_data  <= '0;
            mst_err      <= 1'b0;
            slv_rd_en    <= '0;
            slv_wr_en    <= '0;
            if (violation) err_cnt <= sat_inc(err_cnt);

            case (state)
                // Capture stage: a write wins over a simultaneous read.
                IDLE: begin
                    if (req_any) begin
                        sel_p0    <= req_sel;
                        addr_p0   <= mst_addr[P_SLV_ADDR_W-1:0];
                        wdata_p0  <= mst_wr_data;
                        dir_wr_p0 <= mst_wr_en;
                        if (req_mapped) begin
                            state     <= ISSUE;
                            slv_wr_en <= mst_wr_en ? req_onehot : '0;
                            slv_rd_en <= mst_wr_en ? '0 : req_onehot;
                        end else begin
                            mst_wr_valid <= mst_wr_en;
                            mst_rd_valid <= !mst_wr_en;
                            mst_err      <= 1'b1;
                            mst_rd_data  <= mst_wr_en ? '0 : P_ERR_DATA;
                        end
                    end
                end
                // Response stage: ISSUE already accepts a same-cycle slave answer.
                ISSUE, WAIT: begin
                    if (hit) begin
                        state        <= IDLE;
                        mst_rd_valid <= !dir_wr_p0;
                        mst_wr_valid <= dir_wr_p0;
                        mst_rd_data  <= dir_wr_p0 ? '0 : rd_mux;
                    end else if (state == ISSUE) begin
                        state   <= WAIT;
                        tmo_cnt <= '0;
                    end else if (timeout) begin
                        state        <= IDLE;
                        mst_rd_valid <= !dir_wr_p0;
                        mst_wr_valid <= dir_wr_p0;
                        mst_err      <= 1'b1;
                        mst_rd_data  <= dir_wr_p0 ? '0 : P_ERR_DATA;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
